fetch_prefetch_queue: RTL and testbench

- Instruction-fetch stage upstream of the single-cycle datapath.
- Generates sequential fetch addresses and fetches from instruction memory over a req/ack handshake with variable latency.
- Buffers fetched words with their PC in a DEPTH-entry FIFO and presents them to decode with valid/ready.
- Branch/jump redirect flushes the queue and restarts fetch at the new target, discarding any in-flight response.

---
 rtl/fetch_prefetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage: sequential address generation, single-outstanding imem
// request, and a DEPTH-entry queue of {instr, pc} feeding decode; redirect flushes and restarts.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_plus4,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d, count_nxt;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];

  logic            push, pop, room;
  logic [31:0]     rpc, seq_pc;

  assign rpc       = redirect_pc & ~32'd3;
  assign seq_pc    = addr_q + 32'd4;
  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

  // Pop is suppressed on redirect: the whole queue is being discarded anyway.
  assign push      = (state_q == REQ) && imem_ack && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
  assign count_nxt = count_q + CW'(push) - CW'(pop);
  assign room      = (count_nxt < CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    count_d = count_nxt;
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push);
    if (redirect) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end
    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = REQ;
          fpc_d   = rpc;
          addr_d  = rpc;
        end else if (room) begin
          state_d = REQ;
          addr_d  = fpc_q;
        end
      end
      REQ: begin
        if (imem_ack && !redirect) begin
          fpc_d = seq_pc;
          if (room) addr_d = seq_pc;
          else      state_d = IDLE;
        end else if (redirect) begin
          fpc_d = rpc;
          // Without an ack the old request must still complete, so park in DROP.
          if (imem_ack) addr_d = rpc;
          else          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect) fpc_d = rpc;
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = redirect ? rpc : fpc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Queue storage holds data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]    <= addr_q;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_instr    = out_valid ? instr_mem[rd_q] : 32'd0;
  assign out_pc       = out_valid ? pc_mem[rd_q] : 32'd0;
  assign out_pc_plus4 = out_valid ? (pc_mem[rd_q] + 32'd4) : 32'd0;
  assign occupancy    = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: a latency-configurable memory responder
// plus per-scenario tasks; expected {pc, instr} entries are queued as fetches are acked.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        out_ready = 1'b0;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] next_addr;

  int          mem_lat = 1;
  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = 32'd0;
  int          wcnt = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: acks after mem_lat cycles of a held request, optionally stalling one address.
  always @(posedge clk) begin
    if (imem_req && imem_ack) wcnt = 0;
    else if (imem_req)        wcnt = wcnt + 1;
    else                      wcnt = 0;
    #2;
    imem_ack   = imem_req && !(stall_en && imem_addr == stall_addr) && (wcnt + 1 >= mem_lat);
    imem_rdata = imem_ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b0;
    stall_en = 1'b0;
    mem_lat = 1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_addr = RESET_PC;
  endtask

  // Caller is positioned at a negedge; ends at the negedge after the last cycle.
  task automatic run_stream(input int ncyc, input string tag);
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_out: got pc=%h, required no entry", tag, out_pc);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e || out_instr !== instr_of(e) || out_pc_plus4 !== e + 32'd4) begin
            errors++;
            $display("FAIL %s head: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                     tag, out_pc, out_instr, out_pc_plus4, e, instr_of(e), e + 32'd4);
          end
        end
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== next_addr) begin
        errors++;
        $display("FAIL %s req: got req=%b addr=%h, required req=1 addr=%h", tag, imem_req, imem_addr, next_addr);
      end
      if (i > 1) begin
        checks++;
        if (occupancy !== 3'd1) begin
          errors++;
          $display("FAIL %s occupancy: got %0d, required 1", tag, occupancy);
        end
      end
      if (imem_ack) begin
        sb.push_back(next_addr);
        next_addr = next_addr + 32'd4;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== RESET_PC ||
        out_pc !== 32'd0 || out_instr !== 32'd0 || out_pc_plus4 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got req=%b vld=%b occ=%0d addr=%h pc=%h instr=%h pc4=%h, required all 0",
               imem_req, out_valid, occupancy, imem_addr, out_pc, out_instr, out_pc_plus4);
    end
  endtask

  task automatic test_stream();
    do_reset();
    @(negedge clk);
    run_stream(10, "stream");
  endtask

  task automatic test_full();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL full_fill%0d: got req=%b addr=%h, required req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i));
      end
      sb.push_back(32'(4 * i));
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || occupancy !== 3'd4 || out_valid !== 1'b1 || out_pc !== 32'd0) begin
        errors++;
        $display("FAIL full_hold: got req=%b occ=%0d vld=%b pc=%h, required req=0 occ=4 vld=1 pc=0",
                 imem_req, occupancy, out_valid, out_pc);
      end
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (occupancy !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 32'd16 || out_pc !== 32'd4) begin
      errors++;
      $display("FAIL full_pop: got occ=%0d req=%b addr=%h head=%h (popped %h), required occ=3 req=1 addr=10 head=4",
               occupancy, imem_req, imem_addr, out_pc, e);
    end
    sb.push_back(32'd16);
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd4 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: got occ=%0d req=%b, required occ=4 req=0", occupancy, imem_req);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e || out_instr !== instr_of(e)) begin
        errors++;
        $display("FAIL full_drain%0d: got vld=%b pc=%h instr=%h, required vld=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, e, instr_of(e));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    logic [31:0] e;
    int held;
    do_reset();
    mem_lat = 3;
    out_ready = 1'b1;
    held = 0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        checks++;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
        if (out_pc !== e || out_instr !== instr_of(e)) begin
          errors++;
          $display("FAIL lat_head: got pc=%h instr=%h, required pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
        end
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== next_addr) begin
        errors++;
        $display("FAIL lat_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, next_addr);
      end
      held++;
      if (imem_ack) begin
        checks++;
        if (held !== 3) begin
          errors++;
          $display("FAIL lat_hold: got %0d cycles held, required 3", held);
        end
        sb.push_back(next_addr);
        next_addr = next_addr + 32'd4;
        held = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    stall_en = 1'b1;
    stall_addr = 32'd8;
    @(negedge clk);
    run_stream(2, "drop_pre");
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
      errors++;
      $display("FAIL drop_wait: got req=%b addr=%h, required req=1 addr=8", imem_req, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    sb.delete();
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd8 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL drop_state: got req=%b addr=%h vld=%b occ=%0d, required req=1 addr=8 vld=0 occ=0",
               imem_req, imem_addr, out_valid, occupancy);
    end
    stall_en = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd8 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_ack: got req=%b addr=%h vld=%b, required req=1 addr=8 vld=0", imem_req, imem_addr, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_discard: got vld=%b pc=%h, required vld=0", out_valid, out_pc);
    end
    next_addr = 32'h0000_0100;
    run_stream(5, "drop_post");
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd2 || imem_addr !== 32'd8 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rap_pre: got occ=%0d addr=%h vld=%b, required occ=2 addr=8 vld=1", occupancy, imem_addr, out_valid);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0201;
    out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL rap_post: got occ=%0d vld=%b req=%b addr=%h, required occ=0 vld=0 req=1 addr=200",
               occupancy, out_valid, imem_req, imem_addr);
    end
    next_addr = 32'h0000_0200;
    sb.delete();
    run_stream(4, "rap_stream");
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    next_addr = 32'hFFFF_FFF8;
    run_stream(5, "wrap");
  endtask

  task automatic test_reset_mid_drop();
    do_reset();
    stall_en = 1'b1;
    stall_addr = RESET_PC;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_drop_pre: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_async: got req=%b vld=%b occ=%0d addr=%h, required 0 0 0 %h",
               imem_req, out_valid, occupancy, imem_addr, RESET_PC);
    end
    @(negedge clk);
    stall_en = 1'b0;
    rst_n = 1'b1;
    next_addr = RESET_PC;
    @(negedge clk);
    run_stream(4, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_latency();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
